// File: rtl/fwft_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the head entry is always on o_dout while not empty,
// and i_rd_en acknowledges (pops) it.
module fwft_sync_fifo #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned COUNT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DWIDTH-1:0]      i_din,
  input  logic                   i_wr_en,
  output logic                   o_full,
  input  logic                   i_rd_en,
  output logic [DWIDTH-1:0]      o_dout,
  output logic                   o_empty,
  output logic [COUNT_WIDTH-1:0] o_data_count
);

  localparam int unsigned AW    = COUNT_WIDTH - 1;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DWIDTH-1:0]      r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [COUNT_WIDTH-1:0] w_count_d;

  assign w_full  = (r_count == COUNT_WIDTH'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same edge, so a write alongside a pop is accepted even when full.
  assign w_pop  = i_rd_en && !w_empty;
  assign w_push = i_wr_en && (!w_full || w_pop);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + COUNT_WIDTH'(1);
      2'b01:   w_count_d = r_count - COUNT_WIDTH'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout       = r_mem[r_rd_ptr];
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_data_count = r_count;

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Directed self-checking bench for fwft_sync_fifo: a vector table for the DEAD/BEEF
// handshakes plus hand-written fill/drain, reset and full-boundary sequences.
module tb_fwft_sync_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        wr_en;
  logic        full;
  logic        rd_en;
  logic [15:0] dout;
  logic        empty;
  logic [4:0]  data_count;

  int checks;
  int errors;

  fwft_sync_fifo #(
    .DWIDTH     (16),
    .COUNT_WIDTH(5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_din       (din),
    .i_wr_en     (wr_en),
    .o_full      (full),
    .i_rd_en     (rd_en),
    .o_dout      (dout),
    .o_empty     (empty),
    .o_data_count(data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic        pre_chk;
    logic [15:0] pre_dout;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        post_chk;
    logic [15:0] post_dout;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] d,
                              input logic pc, input logic [15:0] pd, input logic [4:0] c,
                              input logic e, input logic f, input logic qc,
                              input logic [15:0] qd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.pre_chk = pc; v.pre_dout = pd;
    v.cnt = c; v.emp = e; v.ful = f; v.post_chk = qc; v.post_dout = qd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [4:0] c, input logic e,
                           input logic f);
    chk({name, ".count"}, 32'(data_count), 32'(c));
    chk({name, ".empty"}, 32'(empty), 32'(e));
    chk({name, ".full"}, 32'(full), 32'(f));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_state("reset_async", 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;
    rst_n  = 1'b1;
    #2;
    do_reset();

    // Idle after reset
    repeat (30) cyc(1'b0, 1'b0, 16'h0);
    chk_state("idle", 5'd0, 1'b1, 1'b0);

    // Fill/drain with growing n; pointers wrap across iterations
    for (int n = 1; n <= 15; n++) begin
      for (int k = 1; k <= n; k++) begin
        cyc(1'b1, 1'b0, 16'(k));
        chk("fill.count", 32'(data_count), 32'(k));
        chk("fill.empty", 32'(empty), 32'd0);
      end
      for (int k = 1; k <= n; k++) begin
        chk("drain.dout", 32'(dout), 32'(k));
        cyc(1'b0, 1'b1, 16'h0);
        chk("drain.count", 32'(data_count), 32'(n - k));
      end
      chk("drain.empty", 32'(empty), 32'd1);
    end

    // Reset mid-operation discards contents
    for (int n = 1; n <= 15; n++) begin
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 16'(k));
      do_reset();
      chk_state("post_reset", 5'd0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 16'hA500 + 16'(n));
      chk("post_reset.count", 32'(data_count), 32'd1);
      chk("post_reset.dout", 32'(dout), 32'hA500 + 32'(n));
      cyc(1'b0, 1'b1, 16'h0);
      chk("post_reset.drain", 32'(empty), 32'd1);
    end

    // Table-driven handshake vectors
    vecs[0] = mk(1, 0, 16'hDEAD, 0, 16'h0,    5'd1, 0, 0, 1, 16'hDEAD);
    vecs[1] = mk(1, 1, 16'hBEEF, 1, 16'hDEAD, 5'd1, 0, 0, 1, 16'hBEEF);
    vecs[2] = mk(0, 1, 16'h0,    1, 16'hBEEF, 5'd0, 1, 0, 0, 16'h0);
    vecs[3] = mk(0, 1, 16'h0,    0, 16'h0,    5'd0, 1, 0, 0, 16'h0);
    vecs[4] = mk(1, 0, 16'hDEAD, 0, 16'h0,    5'd1, 0, 0, 1, 16'hDEAD);
    vecs[5] = mk(1, 1, 16'hBEEF, 1, 16'hDEAD, 5'd1, 0, 0, 1, 16'hBEEF);
    vecs[6] = mk(0, 0, 16'h0,    1, 16'hBEEF, 5'd1, 0, 0, 1, 16'hBEEF);
    vecs[7] = mk(0, 1, 16'h0,    1, 16'hBEEF, 5'd0, 1, 0, 0, 16'h0);
    vecs[8] = mk(1, 1, 16'h1234, 0, 16'h0,    5'd1, 0, 0, 1, 16'h1234);
    vecs[9] = mk(0, 1, 16'h0,    1, 16'h1234, 5'd0, 1, 0, 0, 16'h0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_chk) chk($sformatf("vec%0d.pre_dout", i), 32'(dout),
                               32'(vecs[i].pre_dout));
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful);
      if (vecs[i].post_chk) chk($sformatf("vec%0d.post_dout", i), 32'(dout),
                                32'(vecs[i].post_dout));
    end

    // Full boundary
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("to_full.full", 32'(full), 32'd0);
      cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
    end
    chk_state("full", 5'd16, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 16'hFFFF);
    chk_state("full_extra_wr", 5'd16, 1'b0, 1'b1);
    chk("full_rw.pre_dout", 32'(dout), 32'h0100);
    cyc(1'b1, 1'b1, 16'h0200);
    chk_state("full_rw", 5'd16, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      chk("full_drain.dout", 32'(dout), (i == 16) ? 32'h0200 : 32'h0100 + 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
      chk("full_drain.count", 32'(data_count), 32'(16 - i));
    end
    chk_state("full_drained", 5'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fwft_sync_fifo.md
Name: fwft_sync_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO used as a generic buffering stage between producer and consumer blocks.
- The head entry is presented on dout whenever the FIFO is not empty. rd_en acts as an acknowledge/pop, not a read request.
- Provides full/empty flags and an occupancy count.

Parameters:
- DWIDTH, 16, data word width in bits.
- COUNT_WIDTH, 5, width of data_count. Storage depth DEPTH = 2**(COUNT_WIDTH-1), 16 by default, so that 0..DEPTH fits in data_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: the FIFO is cleared immediately while rst is low.
- din  in  DWIDTH  write data.
- wr_en  in  1  write strobe; pushes din at the rising edge.
- full  out  1  high when data_count == DEPTH.
- rd_en  in  1  pop strobe; removes the head entry at the rising edge.
- dout  out  DWIDTH  head entry, valid whenever empty is low.
- empty  out  1  high when data_count == 0.
- data_count  out  COUNT_WIDTH  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (rst low, asynchronous):
  - write and read pointers cleared to 0; data_count = 0.
  - empty = 1, full = 0.
  - storage array is not cleared; dout is don't-care while empty.
  - Reset asserted mid-operation discards all contents; the first edge after release behaves as on an empty FIFO.
- Storage: register array of DEPTH x DWIDTH. Write pointer and read pointer are log2(DEPTH)-bit values that wrap modulo DEPTH.
- Write: wr_en=1 and full=0 at a rising edge:
  - mem[wr_ptr] <= din; wr_ptr increments with wrap.
  - wr_en while full is ignored: no pointer or count change, data dropped.
- Read/pop: rd_en=1 and empty=0 at a rising edge: rd_ptr increments with wrap. rd_en while empty is ignored.
- dout is combinational from mem[rd_ptr] (FWFT).
  - A word written into an empty FIFO at edge N appears on dout, with empty low, immediately after edge N: 1-cycle write-to-visible latency.
  - The consumer samples dout in the same cycle it asserts rd_en; the next entry appears after that edge.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: push and pop both occur; data_count is unchanged.
  - Empty: only the write occurs; data_count becomes 1.
  - Full: both occur (pop frees a slot); data_count stays DEPTH.
- Count and flags:
  - data_count is registered, updated at each edge by +1 (push only), -1 (pop only) or 0.
  - empty and full are derived from data_count, or registered equivalently, and are consistent with data_count in every cycle.
- FIFO ordering is strictly preserved across pointer wrap-around.

Test Plan:
- Reset, then idle 30 cycles -> data_count=0, empty=1, full=0.
- For n=1..15: write values 1..n one per cycle -> data_count equals k after the k-th write. Then pop n words with sampling before each pop -> reads 1..n in order, data_count back to 0. Pointers wrap across iterations.
- For n=1..15: write 0..n-1, then pulse rst low for one cycle -> data_count=0, empty=1 after reset.
- Write 16'hDEAD. Next cycle, write 16'hBEEF with rd_en=1 -> dout=DEAD in that cycle. Next cycle, rd_en=1 only -> dout=BEEF. Extra rd_en on the now-empty FIFO is ignored -> data_count=0.
- Write DEAD, then BEEF concurrent with a pop, then one idle cycle -> dout holds BEEF across the idle cycle, then pops -> data_count=0.
- Fill to 16 entries -> full=1, data_count=16. An extra wr_en is ignored. Simultaneous wr_en+rd_en while full -> data_count stays 16 and order is preserved.
